multicycle_control_fsm: RTL and testbench

Sequencing controller for the multi-cycle variant of the RV32I core. It replaces the single-cycle opcode decoder with a state machine that steps one shared ALU and one shared instruction/data memory through fetch, decode, execute, memory and writeback. It supports R-type, I-type ALU, load, store and branch opcodes. Memory accesses use a ready handshake. Per-state strobes drive the datapath's PC, IR, OldPC, A/B and ALUOut registers and its muxes.

---
 rtl/multicycle_control_fsm.sv | 158 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencing controller.
// Steps shared ALU/memory through fetch, decode, execute, memory, writeback.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       PCSrc,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ILLEGAL = 4'd10
  } state_t;

  state_t cur;

  assign state = cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      case (cur)
        S_FETCH:
          if (mem_ready) cur <= S_DECODE;
        S_DECODE:
          if (opcode == OP_LD || opcode == OP_ST)
            cur <= S_MEMADR;
          else if (opcode == OP_R)
            cur <= S_EXEC_R;
          else if (opcode == OP_I)
            cur <= S_EXEC_I;
          else if (opcode == OP_BR)
            cur <= S_BRANCH;
          else begin
            cur     <= S_ILLEGAL;
            illegal <= 1'b1;
          end
        S_MEMADR:
          if (opcode == OP_LD)
            cur <= S_MEMRD;
          else if (opcode == OP_ST)
            cur <= S_MEMWR;
          else begin
            cur     <= S_ILLEGAL;
            illegal <= 1'b1;
          end
        S_MEMRD:
          if (mem_ready) cur <= S_MEMWB;
        S_MEMWB:   cur <= S_FETCH;
        S_MEMWR:
          if (mem_ready) cur <= S_FETCH;
        S_EXEC_R:  cur <= S_ALUWB;
        S_EXEC_I:  cur <= S_ALUWB;
        S_ALUWB:   cur <= S_FETCH;
        S_BRANCH:  cur <= S_FETCH;
        S_ILLEGAL: cur <= S_ILLEGAL;
        default:   cur <= S_FETCH;
      endcase
    end
  end

  // Strobes depend on mem_ready/zero and are killed by reset in the same cycle.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 2'b00;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 1'b0;
    retire   = 1'b0;
    if (!reset) begin
      case (cur)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
        end
        S_MEMADR, S_EXEC_I: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          retire   = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          retire   = mem_ready;
        end
        S_EXEC_R: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b01;
          PCSrc   = 1'b1;
          PCWrite = zero;
          retire  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm.
// Driver queues hand-computed per-cycle expectations; monitor checks them.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, IRWrite, IorD, MemRead, MemWrite;
  logic       MemtoReg, RegWrite, PCSrc, retire, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .state(state), .retire(retire),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_XX = 7'b1111111;

  // {PCWrite,IRWrite,IorD,MemRead,MemWrite,MemtoReg,RegWrite,
  //  ALUSrcA[2],ALUSrcB[2],ALUOp[2],PCSrc,retire,illegal}
  localparam logic [15:0] V_ZERO  = 16'h0000;
  localparam logic [15:0] V_FET1  = 16'hD020;
  localparam logic [15:0] V_FET0  = 16'h1020;
  localparam logic [15:0] V_DEC   = 16'h00C0;
  localparam logic [15:0] V_MADR  = 16'h0140;
  localparam logic [15:0] V_MRD   = 16'h3000;
  localparam logic [15:0] V_MWB   = 16'h0602;
  localparam logic [15:0] V_MWR1  = 16'h2802;
  localparam logic [15:0] V_MWR0  = 16'h2800;
  localparam logic [15:0] V_EXR   = 16'h0110;
  localparam logic [15:0] V_EXI   = 16'h0140;
  localparam logic [15:0] V_AWB   = 16'h0202;
  localparam logic [15:0] V_BRZ1  = 16'h810E;
  localparam logic [15:0] V_BRZ0  = 16'h010E;
  localparam logic [15:0] V_ILL   = 16'h0001;

  typedef struct {
    logic        chk;
    int          id;
    logic [3:0]  st;
    logic [15:0] v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step  = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = q.pop_front();
      act = {PCWrite, IRWrite, IorD, MemRead, MemWrite,
             MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
             PCSrc, retire, illegal};
      if (e.chk) begin
        n_cmp++;
        if (state !== e.st || act !== e.v) begin
          n_bad++;
          $display("FAIL step%0d: got state=%0d out=%h, want state=%0d out=%h",
                   e.id, state, act, e.st, e.v);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic rdy,
                     input logic z, input logic [6:0] op,
                     input logic c, input logic [3:0] es,
                     input logic [15:0] ev);
    exp_t e;
    reset = r;
    mem_ready = rdy;
    zero = z;
    opcode = op;
    e.chk = c;
    e.id = step;
    e.st = es;
    e.v = ev;
    q.push_back(e);
    step++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    zero = 1'b0;
    opcode = 7'd0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, OP_R, 0, 0, V_ZERO);
    cyc(1, 1, 0, OP_R, 1, 0, V_ZERO);
    // R-type
    cyc(0, 1, 0, OP_R, 1, 0, V_FET1);
    cyc(0, 1, 0, OP_R, 1, 1, V_DEC);
    cyc(0, 1, 0, OP_R, 1, 6, V_EXR);
    cyc(0, 1, 0, OP_R, 1, 8, V_AWB);
    // load, three wait cycles in MEMRD
    cyc(0, 1, 0, OP_LD, 1, 0, V_FET1);
    cyc(0, 1, 0, OP_LD, 1, 1, V_DEC);
    cyc(0, 1, 0, OP_LD, 1, 2, V_MADR);
    cyc(0, 0, 0, OP_LD, 1, 3, V_MRD);
    cyc(0, 0, 0, OP_R,  1, 3, V_MRD);
    cyc(0, 0, 1, OP_XX, 1, 3, V_MRD);
    cyc(0, 1, 0, OP_LD, 1, 3, V_MRD);
    cyc(0, 1, 0, OP_LD, 1, 4, V_MWB);
    // branch taken then not taken
    cyc(0, 1, 1, OP_BR, 1, 0, V_FET1);
    cyc(0, 1, 1, OP_BR, 1, 1, V_DEC);
    cyc(0, 1, 1, OP_BR, 1, 9, V_BRZ1);
    cyc(0, 1, 0, OP_BR, 1, 0, V_FET1);
    cyc(0, 1, 0, OP_BR, 1, 1, V_DEC);
    cyc(0, 1, 0, OP_BR, 1, 9, V_BRZ0);
    // store then I-ALU
    cyc(0, 1, 0, OP_ST, 1, 0, V_FET1);
    cyc(0, 1, 0, OP_ST, 1, 1, V_DEC);
    cyc(0, 1, 0, OP_ST, 1, 2, V_MADR);
    cyc(0, 1, 0, OP_ST, 1, 5, V_MWR1);
    cyc(0, 1, 0, OP_I,  1, 0, V_FET1);
    cyc(0, 1, 0, OP_I,  1, 1, V_DEC);
    cyc(0, 1, 0, OP_I,  1, 7, V_EXI);
    cyc(0, 1, 0, OP_I,  1, 8, V_AWB);
    // reset for two cycles while stalled in MEMWR
    cyc(0, 1, 0, OP_ST, 1, 0, V_FET1);
    cyc(0, 1, 0, OP_ST, 1, 1, V_DEC);
    cyc(0, 1, 0, OP_ST, 1, 2, V_MADR);
    cyc(0, 0, 0, OP_ST, 1, 5, V_MWR0);
    cyc(1, 1, 0, OP_ST, 1, 5, V_ZERO);
    cyc(1, 0, 0, OP_ST, 1, 0, V_ZERO);
    cyc(0, 0, 0, OP_XX, 1, 0, V_FET0);
    cyc(0, 1, 0, OP_XX, 1, 0, V_FET1);
    // unsupported opcode is absorbing
    cyc(0, 1, 0, OP_XX, 1, 1, V_DEC);
    for (int i = 0; i < 22; i++) begin
      logic [6:0] op;
      op = (i % 3 == 0) ? OP_R : (i % 3 == 1) ? OP_LD : OP_BR;
      cyc(0, i[0], i[1], op, 1, 10, V_ILL);
    end
    cyc(1, 1, 0, OP_R, 1, 10, V_ILL);
    cyc(0, 1, 0, OP_R, 1, 0, V_FET1);
    cyc(0, 1, 0, OP_R, 1, 1, V_DEC);
    cyc(0, 1, 0, OP_R, 1, 6, V_EXR);
    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
